// File: rtl/lapido_dmem.sv
// lapido_dmem: byte-addressed 32-bit data memory with byte/half/word access,
// sign/zero-extended loads and a LATENCY-cycle req/busy/ready handshake.
// Optional macro DMEM_ALIGN_CHECK_EN: flag misaligned accesses on o_err
// instead of silently forcing them aligned.
module lapido_dmem #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_write_data,
  output logic        o_busy,
  output logic        o_ready,
  output logic [31:0] o_read_data,
  output logic        o_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W+1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_sign_ext;
  logic [31:0]         r_wdata;
  logic [31:0]         r_read_data;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

  logic                w_accept;
  logic                w_wait_done;
  logic                w_access;
  logic                w_a_we;
  logic [ADDR_W+1:0]   w_a_addr;
  logic [1:0]          w_a_size;
  logic                w_a_sign_ext;
  logic [31:0]         w_a_wdata;
  logic [ADDR_W-1:0]   w_idx;
  logic [1:0]          w_lane;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_shift;
  logic [31:0]         w_load;
  logic                w_wr_en;
  logic                w_unused;

  // Address bits above the RAM depth are deliberately dropped (wrap-around).
  assign w_unused = ^i_addr[31:ADDR_W+2];

  assign w_accept    = i_req && (r_state != S_WAIT);
  assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd1);
  // With single-cycle latency the access happens on the accepting edge itself,
  // so it must use the live request rather than the latched copy.
  assign w_access     = (LATENCY == 1) ? w_accept     : w_wait_done;
  assign w_a_we       = (LATENCY == 1) ? i_we         : r_we;
  assign w_a_addr     = (LATENCY == 1) ? i_addr[ADDR_W+1:0] : r_addr;
  assign w_a_size     = (LATENCY == 1) ? i_size       : r_size;
  assign w_a_sign_ext = (LATENCY == 1) ? i_sign_ext   : r_sign_ext;
  assign w_a_wdata    = (LATENCY == 1) ? i_write_data : r_wdata;
  assign w_idx        = w_a_addr[ADDR_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic w_mis;
  logic r_err;
  assign w_mis   = ((w_a_size == 2'b01) && w_a_addr[0]) ||
                   (w_a_size[1] && (w_a_addr[1:0] != 2'b00));
  assign w_wr_en = w_access && w_a_we && !w_mis && !i_rst;
  assign o_err   = r_err && (r_state == S_DONE);
`else
  assign w_wr_en = w_access && w_a_we && !i_rst;
  assign o_err   = 1'b0;
`endif

  // Lane selection, write-data replication and load extraction.
  always_comb begin
    w_lane  = 2'b00;
    w_be    = 4'b1111;
    w_wdata = w_a_wdata;
    case (w_a_size)
      2'b00: begin
        w_lane  = w_a_addr[1:0];
        w_be    = 4'b0001 << w_a_addr[1:0];
        w_wdata = {4{w_a_wdata[7:0]}};
      end
      2'b01: begin
        w_lane  = {w_a_addr[1], 1'b0};
        w_be    = w_a_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_a_wdata[15:0]}};
      end
      default: ;
    endcase
    w_shift = r_mem[w_idx] >> {w_lane, 3'b000};
    case (w_a_size)
      2'b00:   w_load = {{24{w_a_sign_ext & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_load = {{16{w_a_sign_ext & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_DONE;
      default: begin
        if (i_req) w_next = (LATENCY == 1) ? S_DONE : S_WAIT;
        else       w_next = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_busy  = (r_state == S_WAIT);
    o_ready = (r_state == S_DONE);
  end

  // Request latch and latency counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_sign_ext <= 1'b0;
      r_wdata    <= 32'd0;
    end else if (w_accept) begin
      r_cnt      <= 4'(LATENCY - 1);
      r_we       <= i_we;
      r_addr     <= i_addr[ADDR_W+1:0];
      r_size     <= i_size;
      r_sign_ext <= i_sign_ext;
      r_wdata    <= i_write_data;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // RAM write port: byte-lane store on the access edge; contents not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end
  end

  // Load result register, held across stores and idle cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_read_data <= 32'd0;
    end else if (w_access) begin
`ifdef DMEM_ALIGN_CHECK_EN
      if (w_mis)        r_read_data <= 32'd0;
      else if (!w_a_we) r_read_data <= w_load;
`else
      if (!w_a_we) r_read_data <= w_load;
`endif
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Misalignment flag captured on the access edge, shown only while ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_err <= 1'b0;
    else if (w_access) r_err <= w_mis;
  end
`endif

  assign o_read_data = r_read_data;

endmodule

// File: tb/tb_lapido_dmem.sv
// Bench for lapido_dmem: one instance at LATENCY=1, one at LATENCY=4.
// Stimulus pushes expected responses; a monitor pops them on ready.
module tb_lapido_dmem;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req1 = 0, we1 = 0, se1 = 0, busy1, ready1, err1;
  logic [31:0] addr1 = 0, wd1 = 0, rd1;
  logic [1:0]  size1 = 0;
  logic        req4 = 0, we4 = 0, se4 = 0, busy4, ready4, err4;
  logic [31:0] addr4 = 0, wd4 = 0, rd4;
  logic [1:0]  size4 = 0;

  lapido_dmem #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we1), .i_addr(addr1),
    .i_size(size1), .i_sign_ext(se1), .i_write_data(wd1),
    .o_busy(busy1), .o_ready(ready1), .o_read_data(rd1), .o_err(err1));

  lapido_dmem #(.ADDR_W(10), .LATENCY(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_req(req4), .i_we(we4), .i_addr(addr4),
    .i_size(size4), .i_sign_ext(se4), .i_write_data(wd4),
    .o_busy(busy4), .o_ready(ready4), .o_read_data(rd4), .o_err(err4));

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic saw_busy1 = 1'b0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin
    if (busy1 && !rst) saw_busy1 = 1'b1;
    if (ready1) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL d1 spurious ready: got ready with empty queue");
      end else begin
        e1 = q1.pop_front();
        chk("d1 ready cycle", 32'(cyc), 32'(e1.cyc));
        chk("d1 err", {31'b0, err1}, {31'b0, e1.err});
        if (e1.chk_rd) chk("d1 read_data", rd1, e1.rd);
      end
    end
    if (ready4) begin
      if (q4.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL d4 spurious ready: got ready with empty queue");
      end else begin
        e4 = q4.pop_front();
        chk("d4 ready cycle", 32'(cyc), 32'(e4.cyc));
        chk("d4 err", {31'b0, err4}, {31'b0, e4.err});
        if (e4.chk_rd) chk("d4 read_data", rd4, e4.rd);
      end
    end
  end

  // Back-to-back single-cycle requests on the LATENCY=1 instance.
  task automatic issue1(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic se, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic chk_rd, input logic exp_err);
    req1 = 1; we1 = we; addr1 = a; size1 = sz; se1 = se; wd1 = wd;
    q1.push_back('{chk_rd: chk_rd, rd: exp_rd, err: exp_err, cyc: cyc + 1});
    @(negedge clk);
  endtask

  // LATENCY=4 request; a conflicting store is offered while busy and must be ignored.
  task automatic issue4(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic se, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic chk_rd);
    req4 = 1; we4 = we; addr4 = a; size4 = sz; se4 = se; wd4 = wd;
    q4.push_back('{chk_rd: chk_rd, rd: exp_rd, err: 1'b0, cyc: cyc + 4});
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("d4 busy while waiting", {31'b0, busy4}, 32'd1);
      if (i < 2) begin
        req4 = 1; we4 = 1; addr4 = a; size4 = 2'b10; wd4 = 32'hBAD0BAD0;
      end else begin
        req4 = 0;
      end
      @(negedge clk);
    end
    chk("d4 busy at ready", {31'b0, busy4}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk("reset d1 busy",  {31'b0, busy1},  32'd0);
    chk("reset d1 ready", {31'b0, ready1}, 32'd0);
    chk("reset d1 rdata", rd1, 32'd0);
    chk("reset d1 err",   {31'b0, err1},   32'd0);
    chk("reset d4 busy",  {31'b0, busy4},  32'd0);
    chk("reset d4 rdata", rd4, 32'd0);
    rst = 0;
    @(negedge clk);

    // LATENCY=1: word / byte / half accesses, back-to-back.
    issue1(1, 32'h10,   2'b10, 0, 32'hDEADBEEF, 32'h0,        0, 0);
    issue1(0, 32'h10,   2'b10, 0, 32'h0,        32'hDEADBEEF, 1, 0);
    issue1(1, 32'h11,   2'b00, 0, 32'h0000007F, 32'h0,        0, 0);
    issue1(0, 32'h10,   2'b10, 1, 32'h0,        32'hDEAD7FEF, 1, 0);
    issue1(0, 32'h11,   2'b00, 1, 32'h0,        32'h0000007F, 1, 0);
    issue1(0, 32'h13,   2'b00, 1, 32'h0,        32'hFFFFFFDE, 1, 0);
    issue1(0, 32'h12,   2'b01, 1, 32'h0,        32'hFFFFDEAD, 1, 0);
    issue1(0, 32'h12,   2'b01, 0, 32'h0,        32'h0000DEAD, 1, 0);
    issue1(0, 32'h10,   2'b00, 0, 32'h0,        32'h000000EF, 1, 0);
    issue1(0, 32'h10,   2'b00, 1, 32'h0,        32'hFFFFFFEF, 1, 0);
    issue1(0, 32'h10,   2'b11, 1, 32'h0,        32'hDEAD7FEF, 1, 0);
    // Address wrap: 0x1000 aliases word 0.
    issue1(1, 32'h1000, 2'b10, 0, 32'h12345678, 32'h0,        0, 0);
    issue1(0, 32'h0,    2'b10, 0, 32'h0,        32'h12345678, 1, 0);
    // Misaligned word store and half load.
    issue1(1, 32'h20,   2'b10, 0, 32'h11111111, 32'h0,        0, 0);
    issue1(1, 32'h22,   2'b10, 0, 32'hA5A5A5A5, 32'h0,        0, ALIGN);
    issue1(0, 32'h20,   2'b10, 0, 32'h0, ALIGN ? 32'h11111111 : 32'hA5A5A5A5, 1, 0);
    issue1(1, 32'h22,   2'b01, 0, 32'h0000BEEF, 32'h0,        0, 0);
    issue1(0, 32'h20,   2'b10, 0, 32'h0, ALIGN ? 32'hBEEF1111 : 32'hBEEFA5A5, 1, 0);
    issue1(0, 32'h21,   2'b01, 0, 32'h0, ALIGN ? 32'h00000000 : 32'h0000A5A5, 1, ALIGN);
    req1 = 0;
    repeat (2) @(negedge clk);

    // LATENCY=4: store then load with ignored requests while busy.
    issue4(1, 32'h40, 2'b10, 0, 32'hCAFEF00D, 32'h0,        0);
    issue4(0, 32'h40, 2'b10, 0, 32'h0,        32'hCAFEF00D, 1);
    issue4(0, 32'h42, 2'b01, 1, 32'h0,        32'hFFFFCAFE, 1);

    // Reset during WAIT of a store: the store must never land.
    req4 = 1; we4 = 1; addr4 = 32'h40; size4 = 2'b10; wd4 = 32'h55555555;
    @(negedge clk);
    req4 = 0;
    chk("d4 busy before reset", {31'b0, busy4}, 32'd1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid-reset d4 busy",  {31'b0, busy4},  32'd0);
    chk("mid-reset d4 ready", {31'b0, ready4}, 32'd0);
    chk("mid-reset d4 rdata", rd4, 32'd0);
    chk("mid-reset d4 err",   {31'b0, err4},   32'd0);
    q4.delete();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    issue4(0, 32'h40, 2'b10, 0, 32'h0, 32'hCAFEF00D, 1);
    req4 = 0;

    repeat (5) @(negedge clk);
    chk("d1 queue drained", 32'(q1.size()), 32'd0);
    chk("d4 queue drained", 32'(q4.size()), 32'd0);
    chk("d1 busy never high", {31'b0, saw_busy1}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lapido_dmem.md
# lapido_dmem

Parametrised data memory for the core_lapido load/store unit: byte-addressed, 32-bit wide, with byte/halfword/word accesses, byte-lane writes, sign/zero extension on loads, and a configurable-latency request/ready handshake. It sits between the MEM pipeline stage and on-chip RAM. The handshake lets the stage stall for slower memory without changing its interface.

## Interface
- `ADDR_W`, 10, word-address width; depth = 2^ADDR_W 32-bit words.
- `LATENCY`, 1, clock edges from request acceptance to `ready`; legal range 1..15.
- `clk` input 1: the single clock; all logic updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req` input 1: access request; sampled only when `busy`=0.
- `we` input 1: 1 = store, 0 = load.
- `addr` input 32: byte address.
- `size` input 2: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `sign_ext` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `write_data` input 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `busy` output 1: request in flight; new `req` ignored.
- `ready` output 1: one-cycle pulse, access complete.
- `read_data` output 32: load result, valid with `ready`, held until the next load completes.
- `err` output 1: valid with `ready`; misaligned access (only with `DMEM_ALIGN_CHECK_EN`).

## Operation
- FSM states: IDLE, WAIT, DONE. `busy` = (state==WAIT). `ready` = (state==DONE).
- IDLE or DONE with `req`=1 accepts the request:
  - Latch `we`, `addr`, `size`, `sign_ext`, `write_data`.
  - Load counter with LATENCY-1.
  - Go to DONE if LATENCY=1, else to WAIT.
- WAIT: decrement counter; on the edge where it is 0, go to DONE.
- DONE with `req`=0 returns to IDLE.
- The access happens on the edge entering DONE: the store commits and the load samples RAM on that same edge.
- Word index = latched `addr[ADDR_W+1:2]`. Upper address bits are ignored, so accesses wrap modulo depth.
- Lanes are little-endian; `addr[1:0]` selects the lane.
- Stores write only the selected lanes:
  - byte: lane `addr[1:0]`
  - half: lanes `{addr[1],0}` and `{addr[1],1}`
  - word: all four lanes
- Loads extract the selected byte or half and extend it to 32 bits per `sign_ext`. Word loads ignore `sign_ext`.
- Stores leave `read_data` unchanged.
- Reset values: state IDLE, `busy` 0, `ready` 0, `err` 0, `read_data` 0, counter 0. RAM contents are not reset.
- Reset mid-operation: the in-flight request is dropped, and an uncommitted store never writes.

## Timing
- Request accepted at edge E0. `ready` is high during the cycle after edge E0+LATENCY-1, i.e. LATENCY edges after E0 counting E0 itself.
- LATENCY=1: accept at E0, `ready` high in the next cycle, so one access per cycle when `req` is held high.
- Read-after-write to the same word in consecutive requests returns the new data.
- `err` and `ready` assert together; `err` deasserts with `ready`.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: a half at odd address or a word with `addr[1:0]`≠0 is misaligned. Such an access completes with normal timing and `ready`=1, `err`=1. There is no RAM write, and `read_data` is set to 0.
- Not defined: `err` is tied to 0. Misaligned addresses are forced aligned: half clears `addr[0]`, word clears `addr[1:0]`.

## Test plan
- Reset then word store 0xDEADBEEF at 0x10, word load 0x10, LATENCY=1 -> `ready` one cycle after each accept, `read_data`=0xDEADBEEF, `busy` never high.
- Byte store 0x7F at 0x11, then byte load 0x11 with `sign_ext`=1 and byte load 0x13 with `sign_ext`=1 -> word reads 0xDEAD7FEF; results 0x0000007F and 0xFFFFFFDE.
- Half load 0x12 with `sign_ext`=1 and then 0 -> 0xFFFFDEAD and 0x0000DEAD.
- LATENCY=4: load accepted at edge 0 -> `busy` high for 3 cycles, `ready` after edge 3, `req` during `busy` ignored.
- With ADDR_W=10, store to 0x1000 aliases 0x0000 -> load 0x0 returns the stored value. Assert `rst` during WAIT of a store -> the location is unchanged and outputs return to reset values.
- Word store at 0x22: with `DMEM_ALIGN_CHECK_EN`, `err`=1 and word 0x20 unchanged; without it, `err`=0 and word 0x20 is written.
